// File: rtl/pixel_buffer_read_responder_if.sv
// Pixel DMA read bus, frame fill port and status lines of the pixel buffer.
// The master modport is the DMA/fill side, the slave modport is the buffer.
interface pixel_buffer_read_responder_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int PEND_WIDTH = 3
);
    logic [31:0]           pixel_slave_address;
    logic                  pixel_slave_read;
    logic                  pixel_slave_lock;
    logic                  pixel_slave_waitrequest;
    logic [7:0]            pixel_slave_readdata;
    logic                  pixel_slave_readdatavalid;
    logic [ADDR_WIDTH-1:0] fill_address;
    logic                  fill_write;
    logic [7:0]            fill_writedata;
    logic                  fill_waitrequest;
    logic [PEND_WIDTH-1:0] status_pending;
    logic                  status_locked;
    logic                  status_out_of_range;
    logic                  status_clear;

    modport master (
        output pixel_slave_address, pixel_slave_read, pixel_slave_lock,
        output fill_address, fill_write, fill_writedata, status_clear,
        input  pixel_slave_waitrequest, pixel_slave_readdata, pixel_slave_readdatavalid,
        input  fill_waitrequest, status_pending, status_locked, status_out_of_range
    );

    modport slave (
        input  pixel_slave_address, pixel_slave_read, pixel_slave_lock,
        input  fill_address, fill_write, fill_writedata, status_clear,
        output pixel_slave_waitrequest, pixel_slave_readdata, pixel_slave_readdatavalid,
        output fill_waitrequest, status_pending, status_locked, status_out_of_range
    );
endinterface

// File: rtl/pixel_buffer_read_responder.sv
// Byte-wide frame buffer serving pipelined Avalon-MM pixel reads at a fixed
// latency, with a fill write port sharing the single RAM port.
module pixel_buffer_read_responder #(
    parameter int ADDR_WIDTH   = 17,
    parameter int READ_LATENCY = 2,
    parameter int PEND_WIDTH   = 3
) (
    input logic                          sys_clk_clk,
    input logic                          sys_reset_reset,
    pixel_buffer_read_responder_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {GRANT_FILL = 1'b0, GRANT_READ = 1'b1} grant_e;
    typedef enum logic {S_OPEN = 1'b0, S_LOCKED = 1'b1} lock_state_e;

    typedef struct packed {
        logic                  oor;
        logic [ADDR_WIDTH-1:0] addr;
        logic                  lock;
    } rd_req_t;

    logic clk, rst;
    assign clk = sys_clk_clk;
    assign rst = sys_reset_reset;

    rd_req_t     rd_req_s;
    lock_state_e state_q, state_d;
    grant_e      last_grant;
    logic        rd_req, fl_req, rd_gnt, fl_gnt, rd_wait, fl_wait, locked;
    logic        contended;

    assign rd_req   = bus.pixel_slave_read;
    assign fl_req   = bus.fill_write;
    assign rd_req_s = '{oor:  (bus.pixel_slave_address >> ADDR_WIDTH) != 32'd0,
                        addr: bus.pixel_slave_address[ADDR_WIDTH-1:0],
                        lock: bus.pixel_slave_lock};

    // Lock session: state register / next state / outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_OPEN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (rd_gnt) state_d = rd_req_s.lock ? S_LOCKED : S_OPEN;
    end

    // Grants imply acceptance: a granted requester never sees waitrequest.
    always_comb begin
        rd_gnt  = 1'b0;
        fl_gnt  = 1'b0;
        rd_wait = 1'b1;
        fl_wait = 1'b1;
        locked  = (state_q == S_LOCKED);
        if (!rst) begin
            if (locked) begin
                rd_gnt = rd_req;
            end else if (rd_req && fl_req) begin
                rd_gnt = (last_grant == GRANT_FILL);
                fl_gnt = (last_grant == GRANT_READ);
            end else begin
                rd_gnt = rd_req;
                fl_gnt = fl_req;
            end
            rd_wait = rd_req & ~rd_gnt;
            fl_wait = locked | (fl_req & ~fl_gnt);
        end
    end

    assign contended = rd_req & fl_req & (state_q == S_OPEN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            last_grant <= GRANT_FILL;
        else if (contended) last_grant <= rd_gnt ? GRANT_READ : GRANT_FILL;
    end

    // Single-port RAM; the arbiter guarantees at most one access per cycle.
    logic [7:0]            mem [DEPTH];
    logic [7:0]            ram_q;
    logic [ADDR_WIDTH-1:0] ram_addr;

    assign ram_addr = rd_gnt ? rd_req_s.addr : bus.fill_address;

    always_ff @(posedge clk) begin
        if (fl_gnt) mem[ram_addr] <= bus.fill_writedata;
        if (rd_gnt) ram_q <= mem[ram_addr];
    end

    // zero_q masks the RAM output for out-of-range reads and after reset,
    // since the RAM read register itself is never reset.
    logic zero_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         zero_q <= 1'b1;
        else if (rd_gnt) zero_q <= rd_req_s.oor;
    end

    logic [READ_LATENCY:1]      vld_q;
    logic [READ_LATENCY:0]      vld_pipe;
    logic [READ_LATENCY:1][7:0] dat_q;
    logic [READ_LATENCY:1][7:0] dat_pipe;
    logic [7:0]                 stage1_dat;

    assign vld_pipe   = {vld_q, rd_gnt};
    assign stage1_dat = zero_q ? 8'h00 : ram_q;

    always_comb begin
        dat_pipe    = dat_q;
        dat_pipe[1] = stage1_dat;
    end

    // Later data stages load only with a valid, so readdata holds between beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_pipe[READ_LATENCY-1:0];
            for (int k = 2; k <= READ_LATENCY; k++)
                if (vld_pipe[k-1]) dat_q[k] <= dat_pipe[k-1];
        end
    end

    logic [PEND_WIDTH-1:0] pend_q;
    logic                  rdv;
    assign rdv = vld_pipe[READ_LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            case ({rd_gnt, rdv})
                2'b10:   pend_q <= pend_q + PEND_WIDTH'(1);
                2'b01:   pend_q <= pend_q - PEND_WIDTH'(1);
                default: pend_q <= pend_q;
            endcase
        end
    end

    logic oor_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        oor_q <= 1'b0;
        else if (rd_gnt && rd_req_s.oor) oor_q <= 1'b1;
        else if (bus.status_clear)       oor_q <= 1'b0;
    end

    assign bus.pixel_slave_waitrequest   = rd_wait;
    assign bus.fill_waitrequest          = fl_wait;
    assign bus.pixel_slave_readdatavalid = rdv;
    assign bus.pixel_slave_readdata      = dat_pipe[READ_LATENCY];
    assign bus.status_pending            = pend_q;
    assign bus.status_locked             = locked;
    assign bus.status_out_of_range       = oor_q;
endmodule
